pipeline_hazard_ctrl: RTL and testbench

//  Central sequencer for the 5-stage RISC-V pipeline (IF/ID/EX/M/WB).
//  - Gates PC and IF_ID enables, inserts bubbles on load-use hazards, squashes wrong-path instructions on taken branch/jump resolved in M.
//  - Handles start/stop: on enable deassert it drains in-flight instructions before halting.
//  - Sits beside the control unit; drives the en/flush inputs of the pipeline registers.

---
 rtl/pipeline_hazard_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//   Central sequencer for a 5-stage RISC-V pipeline (IF/ID/EX/M/WB).
//   It gates the PC and IF_ID enables and inserts a bubble on a load-use
//   hazard. It squashes wrong-path instructions when a branch or jump is
//   taken in M. When the run request drops, it drains the in-flight
//   instructions before halting.
//
//   Optional feature macro: PERF_CNT_EN
//     Defined   -> stall_cnt / flush_cnt ports and saturating counters exist.
//     Undefined -> no counter ports and no counter flops.
//
// Parameters
//   DRAIN_CYCLES  cycles spent in DRAIN before IDLE (legal 1..15)
//   CNT_W         performance counter width (PERF_CNT_EN only)
//
// Ports
//   clk, srst          clock, synchronous active-high reset
//   enable             run request (level)
//   id_rs1, id_rs2     source registers of the instruction in ID
//   id_uses_rs2        ID instruction reads rs2
//   id_ex_rd           rd of the instruction in EX
//   id_ex_mem_read     EX instruction is a load
//   ex_m_branch/zero/jump  M-stage branch resolution inputs
//   pc_en, pc_redirect PC update enable / select branch-jump target
//   if_id_en           IF_ID register enable
//   if_id_flush        IF_ID loads NOP
//   id_ex_flush        ID_EX control fields load zero
//   ex_m_flush         EX_M control fields load zero
//   running, halted    state==RUN / state==IDLE
//   dbg_state          raw FSM state (IDLE=0, RUN=1, DRAIN=2)
//   stall_cnt          load-use stall cycles (PERF_CNT_EN)
//   flush_cnt          taken-redirect cycles (PERF_CNT_EN)
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
  parameter int unsigned DRAIN_CYCLES = 4,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             enable,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs2,
  input  logic [4:0]       id_ex_rd,
  input  logic             id_ex_mem_read,
  input  logic             ex_m_branch,
  input  logic             ex_m_zero,
  input  logic             ex_m_jump,
  output logic             pc_en,
  output logic             pc_redirect,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_m_flush,
  output logic             running,
  output logic             halted,
  output logic [1:0]       dbg_state
`ifdef PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_dcnt;
  logic [3:0] w_dcnt_nxt;

  logic w_taken;
  logic w_luh;
  logic w_stall;

  // A taken branch/jump resolved in M.
  assign w_taken = (ex_m_branch & ex_m_zero) | ex_m_jump;

  // Load in EX whose rd feeds the instruction in ID; x0 never hazards.
  assign w_luh = id_ex_mem_read && (id_ex_rd != 5'd0) &&
                 ((id_ex_rd == id_rs1) || (id_uses_rs2 && (id_ex_rd == id_rs2)));

  // A stall only happens while instructions flow; taken squashes the
  // stalled instruction instead, so it is not a stall.
  assign w_stall = w_luh && !w_taken && (r_state != IDLE);

  always_ff @(posedge clk) begin
    if (srst) begin
      r_state <= IDLE;
      r_dcnt  <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_dcnt  <= w_dcnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_dcnt_nxt  = r_dcnt;
    pc_en       = 1'b0;
    pc_redirect = 1'b0;
    if_id_en    = 1'b0;
    if_id_flush = 1'b1;
    id_ex_flush = 1'b1;
    ex_m_flush  = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (enable) begin
          w_state_nxt = RUN;
        end
      end

      RUN: begin
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        if (w_taken) begin
          pc_redirect = 1'b1;
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          ex_m_flush  = 1'b1;
        end else if (w_luh) begin
          pc_en       = 1'b0;
          if_id_en    = 1'b0;
          id_ex_flush = 1'b1;
        end
        if (!enable) begin
          w_state_nxt = DRAIN;
          w_dcnt_nxt  = DRAIN_LOAD;
        end
      end

      DRAIN: begin
        // Bubbles enter ID while older instructions advance.
        if_id_en    = 1'b1;
        id_ex_flush = 1'b0;
        if (w_taken) begin
          // Redirect anyway so the PC holds the correct resume address.
          pc_en       = 1'b1;
          pc_redirect = 1'b1;
          id_ex_flush = 1'b1;
          ex_m_flush  = 1'b1;
        end else if (w_luh) begin
          // Hold IF_ID (no NOP overwrite) so the stalled instruction survives.
          if_id_en    = 1'b0;
          if_id_flush = 1'b0;
          id_ex_flush = 1'b1;
        end
        if (enable) begin
          w_state_nxt = RUN;
          w_dcnt_nxt  = 4'd0;
        end else if (r_dcnt == 4'd0) begin
          w_state_nxt = IDLE;
        end else begin
          w_dcnt_nxt = r_dcnt - 4'd1;
        end
      end

      default: begin
        w_state_nxt = IDLE;
        w_dcnt_nxt  = 4'd0;
      end
    endcase
  end

  assign running   = (r_state == RUN);
  assign halted    = (r_state == IDLE);
  assign dbg_state = r_state;

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  // Saturating counters, cleared only by srst.
  always_ff @(posedge clk) begin
    if (srst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (pc_redirect && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`else
  logic w_unused;
  assign w_unused = w_stall;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
//   Directed bench for pipeline_hazard_ctrl. Inputs change 1 ns after a rising
//   edge, and the combinational outputs are sampled 1 ns later, well clear of
//   the next edge. The expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

  localparam int CNT_W = 4;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       srst, enable;
  logic [4:0] id_rs1, id_rs2, id_ex_rd;
  logic       id_uses_rs2, id_ex_mem_read;
  logic       ex_m_branch, ex_m_zero, ex_m_jump;
  logic       pc_en, pc_redirect, if_id_en, if_id_flush, id_ex_flush, ex_m_flush;
  logic       running, halted;
  logic [1:0] dbg_state;
`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
`endif

  pipeline_hazard_ctrl #(.DRAIN_CYCLES(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .srst(srst), .enable(enable),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
    .id_ex_rd(id_ex_rd), .id_ex_mem_read(id_ex_mem_read),
    .ex_m_branch(ex_m_branch), .ex_m_zero(ex_m_zero), .ex_m_jump(ex_m_jump),
    .pc_en(pc_en), .pc_redirect(pc_redirect), .if_id_en(if_id_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .ex_m_flush(ex_m_flush),
    .running(running), .halted(halted), .dbg_state(dbg_state)
`ifdef PERF_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  // scoreboard helpers
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compares the six control outputs packed as
  // {pc_en, pc_redirect, if_id_en, if_id_flush, id_ex_flush, ex_m_flush}.
  task automatic check_ctl(input string tag, input logic [5:0] exp);
    check(tag, {26'd0, pc_en, pc_redirect, if_id_en, if_id_flush, id_ex_flush, ex_m_flush},
          {26'd0, exp});
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_in();
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs2 = 1'b0;
    id_ex_rd = 5'd0; id_ex_mem_read = 1'b0;
    ex_m_branch = 1'b0; ex_m_zero = 1'b0; ex_m_jump = 1'b0;
  endtask

  task automatic set_luh(input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic uses2);
    id_ex_mem_read = 1'b1; id_ex_rd = rd; id_rs1 = rs1; id_rs2 = rs2; id_uses_rs2 = uses2;
  endtask

  initial begin
    // 1. reset / start
    srst = 1'b1; enable = 1'b0; clear_in();
    tick(); tick(); settle();
    check("rst_halted", {31'd0, halted}, 32'd1);
    check("rst_running", {31'd0, running}, 32'd0);
    check_ctl("rst_ctl", 6'b000110);
    check("rst_state", {30'd0, dbg_state}, 32'd0);

    srst = 1'b0; enable = 1'b1; settle();
    check_ctl("idle_en_ctl", 6'b000110);
    tick(); settle();
    check("run_running", {31'd0, running}, 32'd1);
    check_ctl("run_ctl", 6'b101000);

    // 2. load-use via rs1 -> one stall cycle
    set_luh(5'd5, 5'd5, 5'd0, 1'b0); settle();
    check_ctl("luh_rs1", 6'b000010);
    tick(); clear_in(); settle();
    check_ctl("luh_rs1_after", 6'b101000);
    // rs2 match but rs2 unused -> no stall
    set_luh(5'd5, 5'd0, 5'd5, 1'b0); settle();
    check_ctl("luh_rs2_unused", 6'b101000);
    // rs2 match and used -> stall
    id_uses_rs2 = 1'b1; settle();
    check_ctl("luh_rs2_used", 6'b000010);
    tick(); clear_in();
    // rd = x0 never stalls
    set_luh(5'd0, 5'd0, 5'd0, 1'b1); settle();
    check_ctl("luh_x0", 6'b101000);
    tick(); clear_in(); settle();

    // 3. branch / jump
    ex_m_branch = 1'b1; ex_m_zero = 1'b1; settle();
    check_ctl("br_taken", 6'b111111);
    tick(); ex_m_zero = 1'b0; settle();
    check_ctl("br_not_taken", 6'b101000);
    tick(); clear_in(); ex_m_jump = 1'b1; settle();
    check_ctl("jump", 6'b111111);

    // 4. priority: luh + taken -> redirect wins, no stall
    tick(); set_luh(5'd7, 5'd7, 5'd0, 1'b0); settle();
    check_ctl("prio", 6'b111111);
    tick(); clear_in(); set_luh(5'd9, 5'd0, 5'd9, 1'b1); settle();
    check_ctl("stall3", 6'b000010);
    tick(); clear_in(); settle();
`ifdef PERF_CNT_EN
    // stalls: rs1, rs2-used, stall3; redirects: branch, jump, prio
    check("perf_stall3", {28'd0, stall_cnt}, 32'd3);
    check("perf_flush3", {28'd0, flush_cnt}, 32'd3);
`endif

    // 5. drain for exactly 4 cycles
    enable = 1'b0; settle();
    check_ctl("drain_entry_run", 6'b101000);
    for (int i = 0; i < 4; i++) begin
      tick(); settle();
      check($sformatf("drain%0d_state", i), {30'd0, dbg_state}, 32'd2);
      check_ctl($sformatf("drain%0d_ctl", i), 6'b001100);
    end
    tick(); settle();
    check("drain_halted", {31'd0, halted}, 32'd1);

    // restart, then drain with a jump, a stall and a re-enable in cycle 2
    enable = 1'b1; tick(); settle();
    check("restart_running", {31'd0, running}, 32'd1);
    enable = 1'b0; tick(); ex_m_jump = 1'b1; settle();
    check_ctl("drain_jump", 6'b111111);
    tick(); clear_in(); enable = 1'b1; set_luh(5'd3, 5'd3, 5'd0, 1'b0); settle();
    check("drain2_state", {30'd0, dbg_state}, 32'd2);
    check_ctl("drain_luh", 6'b000010);
    tick(); clear_in(); settle();
    check("reenable_running", {31'd0, running}, 32'd1);
`ifdef PERF_CNT_EN
    check("perf_stall4", {28'd0, stall_cnt}, 32'd4);
    check("perf_flush4", {28'd0, flush_cnt}, 32'd4);

    // 6. saturation: 20 more stall cycles on a 4-bit counter
    set_luh(5'd4, 5'd4, 5'd0, 1'b0);
    for (int i = 0; i < 20; i++) tick();
    clear_in(); settle();
    check("perf_stall_sat", {28'd0, stall_cnt}, 32'd15);
`endif

    // mid-run synchronous reset
    check("pre_srst_running", {31'd0, running}, 32'd1);
    srst = 1'b1; tick(); settle();
    check("srst_halted", {31'd0, halted}, 32'd1);
    check_ctl("srst_ctl", 6'b000110);
`ifdef PERF_CNT_EN
    check("srst_stall_cnt", {28'd0, stall_cnt}, 32'd0);
    check("srst_flush_cnt", {28'd0, flush_cnt}, 32'd0);
`endif

    // final report
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
